// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master dmem arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;
  typedef logic master_idx_t;

  localparam int LOCK_CNT_W = 8;
  localparam int WORD_LSB   = 2;
  localparam int NUM_M      = 2;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return ({{WORD_LSB{1'b0}}, addr[31:WORD_LSB]} < 32'(depth));
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// Master-side handshake and dmem bus for dmem_arbiter; slave = arbiter view.
interface dmem_arbiter_if;
  logic        m0_req,    m1_req;
  logic        m0_we,     m1_we;
  logic [31:0] m0_addr,   m1_addr;
  logic [31:0] m0_wdata,  m1_wdata;
  logic        m0_lock,   m1_lock;
  logic        m0_gnt,    m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata,  m1_rdata;
  logic        m0_err,    m1_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_lock, m1_lock, mem_rd,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           m0_err, m1_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_lock, m1_lock, mem_rd,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           m0_err, m1_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arb_resp.sv
// Per-master response register: rvalid/rdata/err one cycle after the grant.
module dmem_arb_resp (
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt_i,
  input  logic        we_i,
  input  logic        in_range_i,
  input  logic [31:0] mem_rd_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  logic        rvalid_d, rvalid_q;
  logic [31:0] rdata_d,  rdata_q;
  logic        err_d,    err_q;

  always_comb begin
    rvalid_d = gnt_i;
    rdata_d  = (gnt_i && !we_i && in_range_i) ? mem_rd_i : 32'h0;
    err_d    = gnt_i && !in_range_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter for the single-port dmem.
// Optional bounded bus lock for bursts is built when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LOCK_MAX    = 8
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  logic [NUM_M-1:0]       req, we, lock, in_rng, gnt_raw, gnt, rvalid, err;
  logic [NUM_M-1:0][31:0] addr, wdata, rdata;

  assign req   = {bus.m1_req,   bus.m0_req};
  assign we    = {bus.m1_we,    bus.m0_we};
  assign lock  = {bus.m1_lock,  bus.m0_lock};
  assign addr  = {bus.m1_addr,  bus.m0_addr};
  assign wdata = {bus.m1_wdata, bus.m0_wdata};

  for (genvar k = 0; k < NUM_M; k++) begin : g_rng
    assign in_rng[k] = addr_in_range(addr[k], DEPTH_WORDS);
  end

  arb_state_t  state_q, state_d;
  master_idx_t last_q, last_d, sel;

  // A locked owner is the only eligible master; otherwise the non-last master wins ties.
  always_comb begin
    gnt_raw = '0;
    case (state_q)
      LOCK0:   gnt_raw[0] = req[0];
      LOCK1:   gnt_raw[1] = req[1];
      default: begin
        if (&req) gnt_raw[~last_q] = 1'b1;
        else      gnt_raw = req;
      end
    endcase
    gnt    = gnt_raw & {NUM_M{reset}};
    sel    = gnt[1];
    last_d = (|gnt) ? sel : last_q;
  end

`ifdef DMEM_ARB_LOCK_EN
  localparam logic [LOCK_CNT_W-1:0] LOCK_MAX_C = LOCK_CNT_W'(LOCK_MAX);
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
  master_idx_t           own;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own     = (state_q == LOCK1);
    case (state_q)
      IDLE: begin
        if ((|gnt) && lock[sel] && (LOCK_MAX_C > LOCK_CNT_W'(1))) begin
          state_d = sel ? LOCK1 : LOCK0;
          cnt_d   = LOCK_CNT_W'(1);
        end
      end
      LOCK0, LOCK1: begin
        if (gnt[own]) cnt_d = cnt_q + LOCK_CNT_W'(1);
        // last already equals the owner here, so release hands the next tie to the other master
        if (!req[own] || !lock[own] || (cnt_d >= LOCK_MAX_C)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  always_comb state_d = IDLE;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // With no grant sel is 0, so the bus follows master 0.
  assign bus.mem_a  = addr[sel];
  assign bus.mem_wd = wdata[sel];
  assign bus.mem_we = (|gnt) & we[sel] & in_rng[sel];

  for (genvar k = 0; k < NUM_M; k++) begin : g_resp
    dmem_arb_resp u_resp (
      .clk       (clk),
      .reset     (reset),
      .gnt_i     (gnt[k]),
      .we_i      (we[k]),
      .in_range_i(in_rng[k]),
      .mem_rd_i  (bus.mem_rd),
      .rvalid_o  (rvalid[k]),
      .rdata_o   (rdata[k]),
      .err_o     (err[k])
    );
  end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rvalid[0];
  assign bus.m1_rvalid = rvalid[1];
  assign bus.m0_rdata  = rdata[0];
  assign bus.m1_rdata  = rdata[1];
  assign bus.m0_err    = err[0];
  assign bus.m1_err    = err[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (owner/burst bookkeeping, word array, pending responses).
module tb_dmem_arbiter;
  localparam int DEPTH    = 64;
  localparam int LOCK_MAX = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH_WORDS(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [1:0]  t_req = '0, t_we = '0, t_lock = '0;
  logic [31:0] t_addr [2];
  logic [31:0] t_wd   [2];
  logic [31:0] dm     [DEPTH];

  assign bus.m0_req = t_req[0];   assign bus.m1_req = t_req[1];
  assign bus.m0_we = t_we[0];     assign bus.m1_we = t_we[1];
  assign bus.m0_lock = t_lock[0]; assign bus.m1_lock = t_lock[1];
  assign bus.m0_addr = t_addr[0]; assign bus.m1_addr = t_addr[1];
  assign bus.m0_wdata = t_wd[0];  assign bus.m1_wdata = t_wd[1];

  // Behavioural dmem: combinational read, write on the rising edge.
  assign bus.mem_rd = ({2'b00, bus.mem_a[31:2]} < 32'(DEPTH)) ? dm[bus.mem_a[7:2]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (bus.mem_we) dm[bus.mem_a[7:2]] <= bus.mem_wd;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          last_m = 1, owner = -1, burst = 0, last_win = -1;
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];
  logic        exp_er [2];

  function automatic bit inr(input logic [31:0] a);
    return a[31:2] < 30'(DEPTH);
  endfunction

  task automatic model_reset();
    last_m = 1; owner = -1; burst = 0; last_win = -1;
    for (int k = 0; k < 2; k++) begin exp_rv[k] = 0; exp_rd[k] = 0; exp_er[k] = 0; end
  endtask

  // Called mid-cycle: checks this cycle's grant/bus and last cycle's responses.
  task automatic model_step();
    int win = -1;
    chk("m0_rvalid", bus.m0_rvalid, exp_rv[0]);
    chk("m0_rdata",  bus.m0_rdata,  exp_rd[0]);
    chk("m0_err",    bus.m0_err,    exp_er[0]);
    chk("m1_rvalid", bus.m1_rvalid, exp_rv[1]);
    chk("m1_rdata",  bus.m1_rdata,  exp_rd[1]);
    chk("m1_err",    bus.m1_err,    exp_er[1]);
    if (owner >= 0) begin
      if (t_req[owner]) win = owner;
    end else if (t_req == 2'b11) win = 1 - last_m;
    else if (t_req[0]) win = 0;
    else if (t_req[1]) win = 1;
    chk("m0_gnt", bus.m0_gnt, 32'(win == 0));
    chk("m1_gnt", bus.m1_gnt, 32'(win == 1));
    chk("mem_we", bus.mem_we, 32'(win >= 0 && t_we[win] && inr(t_addr[win])));
    chk("mem_a",  bus.mem_a,  (win >= 0) ? t_addr[win] : t_addr[0]);
    chk("mem_wd", bus.mem_wd, (win >= 0) ? t_wd[win] : t_wd[0]);
    for (int k = 0; k < 2; k++) begin
      exp_rv[k] = (win == k);
      exp_er[k] = (win == k) && !inr(t_addr[k]);
      exp_rd[k] = ((win == k) && !t_we[k] && inr(t_addr[k])) ? ref_mem[t_addr[k][7:2]] : 32'h0;
    end
    if (win >= 0 && t_we[win] && inr(t_addr[win])) ref_mem[t_addr[win][7:2]] = t_wd[win];
    if (win >= 0) last_m = win;
    last_win = win;
`ifdef DMEM_ARB_LOCK_EN
    if (owner < 0) begin
      if (win >= 0 && t_lock[win] && LOCK_MAX > 1) begin owner = win; burst = 1; end
    end else begin
      if (win == owner) burst++;
      if (!t_req[owner] || !t_lock[owner] || burst >= LOCK_MAX) owner = -1;
    end
`endif
  endtask

  task automatic step(); @(negedge clk); model_step(); endtask
  task automatic nxt();  @(posedge clk); #1; endtask

  task automatic drv(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic l);
    t_req[k] = r; t_we[k] = w; t_addr[k] = a; t_wd[k] = d; t_lock[k] = l;
  endtask

  task automatic rand_master(input int k);
    int w = $urandom_range(0, 71);
    t_req[k]  = ($urandom_range(0, 99) < 65);
    t_we[k]   = $urandom_range(0, 1);
    t_lock[k] = ($urandom_range(0, 99) < 30);
    t_wd[k]   = $urandom;
    t_addr[k] = ($urandom_range(0, 19) == 0) ? $urandom : ((32'(w) << 2) | 32'($urandom_range(0, 3)));
  endtask

  int cnt;
  initial begin
    for (int i = 0; i < DEPTH; i++) begin dm[i] = 0; ref_mem[i] = 0; end
    for (int k = 0; k < 2; k++) begin t_addr[k] = 0; t_wd[k] = 0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {bus.m1_gnt, bus.m0_gnt}, 0);
    chk("rst_rv",  {bus.m1_rvalid, bus.m0_rvalid, bus.m1_err, bus.m0_err, bus.mem_we}, 0);
    chk("rst_rd",  bus.m0_rdata | bus.m1_rdata, 0);
    reset = 1'b1;

    // Single write then read-back
    drv(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0);
    step(); chk("wr_gnt", bus.m0_gnt, 1); chk("wr_we", bus.mem_we, 1); nxt();
    drv(0, 0, 0, 32'h0, 32'h0, 0);
    step(); chk("wr_rvalid", bus.m0_rvalid, 1); chk("wr_rdata", bus.m0_rdata, 0); nxt();
    drv(0, 1, 0, 32'h10, 32'h0, 0);
    step(); nxt();
    drv(0, 0, 0, 32'h0, 32'h0, 0);
    step(); chk("rb_rdata", bus.m0_rdata, 32'hDEAD_BEEF); nxt();

    // Both read continuously: alternating grants
    drv(0, 1, 0, 32'h10, 0, 0); drv(1, 1, 0, 32'h14, 0, 0);
    repeat (6) begin step(); nxt(); end
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);

    // Same-word write (m1) vs read (m0): m0 reads old, then m1 writes, re-read sees new
    drv(0, 1, 1, 32'h20, 32'h1111_1111, 0); step(); nxt();
    drv(0, 0, 0, 0, 0, 0); drv(1, 1, 0, 32'h0, 0, 0); step(); nxt();
    drv(1, 1, 1, 32'h20, 32'h5, 0); drv(0, 1, 0, 32'h20, 0, 0);
    step(); chk("cf_gnt0", bus.m0_gnt, 1); nxt();
    drv(0, 0, 0, 0, 0, 0);
    step(); chk("cf_old", bus.m0_rdata, 32'h1111_1111); chk("cf_gnt1", bus.m1_gnt, 1); nxt();
    drv(1, 0, 0, 0, 0, 0); drv(0, 1, 0, 32'h20, 0, 0); step(); nxt();
    drv(0, 0, 0, 0, 0, 0);
    step(); chk("cf_new", bus.m0_rdata, 32'h5); nxt();

    // Out-of-range read
    drv(0, 1, 0, 32'h100, 0, 0); step(); chk("oor_we", bus.mem_we, 0); nxt();
    drv(0, 0, 0, 0, 0, 0);
    step(); chk("oor_err", bus.m0_err, 1); chk("oor_rdata", bus.m0_rdata, 0); nxt();

    // Locked burst by m1 against continuous m0 requests
    drv(1, 1, 0, 32'h8, 0, 1); drv(0, 1, 0, 32'h4, 0, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.m0_gnt) begin nxt(); break; end
      if (bus.m1_gnt) cnt++;
      nxt();
    end
`ifdef DMEM_ARB_LOCK_EN
    chk("lock_burst", cnt, LOCK_MAX);
`else
    chk("rr_burst", cnt, 1);
`endif

    // Reset while m1 owns the bus
    drv(0, 0, 0, 0, 0, 0); drv(1, 1, 0, 32'hC, 0, 1);
    step(); nxt(); step(); nxt();
    drv(0, 1, 0, 32'h4, 0, 0);
    reset = 1'b0; #1;
    chk("mr_gnt", {bus.m1_gnt, bus.m0_gnt}, 0);
    chk("mr_out", {bus.m1_rvalid, bus.m0_rvalid, bus.m1_err, bus.m0_err, bus.mem_we}, 0);
    chk("mr_rd",  bus.m0_rdata | bus.m1_rdata, 0);
    model_reset();
    nxt(); nxt();
    reset = 1'b1;
    step(); chk("mr_first", bus.m0_gnt, 1); nxt();

    // Random traffic; requests held until granted
    for (int i = 0; i < 600; i++) begin
      step(); nxt();
      for (int k = 0; k < 2; k++)
        if (!(t_req[k] && last_win != k)) rand_master(k);
    end
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    step(); nxt();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Two-master arbiter sharing the single-port data memory `dmem` between the CPU load/store port (master 0) and a second requester such as DMA or a debug loader (master 1).
- Grants at most one access per cycle, round-robin fair, with an optional bounded bus lock for multi-word bursts.
- Read data and error status are returned to each master one cycle after its grant.
- Sits between the core's memory stage and `dmem`; drives `dmem`'s `we`, `a` and `wd`, and samples its combinational `rd`.

## Interface
- `DEPTH_WORDS`, 64: number of addressable 32-bit words in `dmem`.
- `LOCK_MAX`, 8: maximum consecutive locked grants to one master (1..255).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` input 1: access request; held until granted.
- `m0_we`, `m1_we` input 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` input 32: byte address; bits [1:0] ignored.
- `m0_wdata`, `m1_wdata` input 32: write data.
- `m0_lock`, `m1_lock` input 1: request to keep ownership after this access (used only with `DMEM_ARB_LOCK_EN`).
- `m0_gnt`, `m1_gnt` output 1: access performed this cycle (combinational).
- `m0_rvalid`, `m1_rvalid` output 1: response valid, one cycle after the grant.
- `m0_rdata`, `m1_rdata` output 32: read data for the response (0 for writes and errors).
- `m0_err`, `m1_err` output 1: out-of-range address, qualified by `rvalid`.
- `mem_we` output 1, `mem_a` output 32, `mem_wd` output 32: to `dmem`.
- `mem_rd` input 32: from `dmem`.

## Operation
- **Address range:** an address is in range when `addr[31:2] < DEPTH_WORDS`.
  - Out-of-range grants force `mem_we=0`.
  - The response is `err=1` with `rdata=0`.
- **Memory drive:**
  - `mem_a` = the granted master's address; `mem_wd` = its write data.
  - `mem_we` = `gnt & we & in_range`.
  - With no grant, `mem_we=0` and `mem_a`/`mem_wd` follow master 0's inputs.
- **Round-robin:** a 1-bit `last` register records the most recent winner.
  - Sole requester wins.
  - When both request, the master ≠ `last` wins.
  - `last` updates on every grant.
  - At reset `last=1`, so master 0 wins the first contention.
- **Lock FSM**, states `IDLE`, `LOCK0`, `LOCK1`:
  - `IDLE` → `LOCKk` when master k is granted with `mk_lock=1`. The lock counter is loaded to 1.
  - In `LOCKk`, master k is the only master eligible. If `mk_req=1` it is granted and the counter increments.
  - `LOCKk` → `IDLE` after a cycle in which `mk_req=0`, `mk_lock=0`, or the counter reaches `LOCK_MAX`.
  - On a forced release, `last=k`, so the other master wins the next contention.
  - While in `LOCKk` with `mk_req=0`, nobody is granted that cycle, then the FSM returns to `IDLE`.
- **Response registers:** each cycle, `mk_rvalid <= mk_gnt`.
  - `mk_rdata <= (gnt & !we & in_range) ? mem_rd : 0`.
  - `mk_err <= gnt & !in_range`.
- **Same-cycle conflict:** a write by one master and a read of the same word by the other are serialized. The read granted later sees the new data.

## Timing
- Grant latency is 0 cycles: `gnt` is asserted in the same cycle as `req` when arbitration is won.
- The write commits at the rising edge that ends the grant cycle.
- Response (`rvalid`/`rdata`/`err`) appears in cycle N+1 for a grant in cycle N.
- Back-to-back grants to one master give back-to-back `rvalid`.
- Reset values:
  - All `gnt`, `rvalid`, `err` and `mem_we` = 0.
  - All `rdata` = 0.
  - FSM = `IDLE`, lock counter = 0, `last` = 1.
  - `gnt` is gated low while `reset` is asserted.
- Reset asserted mid-lock or mid-response: state clears immediately and any pending response is dropped.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: the lock FSM and counter are built as described above.
- `DMEM_ARB_LOCK_EN` undefined:
  - `mk_lock` inputs are ignored.
  - The FSM stays in `IDLE` and the counter is not built.
  - Arbitration is pure per-cycle round-robin.

## Structure
- **Package `dmem_arb_pkg`:**
  - `arb_state_t` enum (`IDLE`, `LOCK0`, `LOCK1`).
  - `master_idx_t` (1 bit).
  - Lock counter width constant (8).
  - `WORD_LSB = 2`.
- **Sub-module `dmem_arb_resp`:** per-master response register (`rvalid`/`rdata`/`err`), instantiated twice.

## Test plan
- Reset, then `m0` writes `0xDEADBEEF` to address `0x10` → `m0_gnt=1` same cycle, `mem_we=1`, `m0_rvalid=1` next cycle with `rdata=0`; a later `m0` read of `0x10` returns `0xDEADBEEF`.
- Both masters request reads every cycle → grants alternate 0,1,0,1; each `rvalid` follows its `gnt` by one cycle.
- `m1` writes `0x5` to address `0x20` while `m0` reads `0x20` in the same cycle → `m0` granted first and reads the old value; `m1` is granted next; a re-read by `m0` returns `0x5`.
- `m0` reads address `0x100` (word 64) → `mem_we=0`, next cycle `m0_rvalid=1`, `m0_err=1`, `m0_rdata=0`.
- With `DMEM_ARB_LOCK_EN` and `LOCK_MAX=8`, `m1` requests with lock held and `m0` requests continuously → `m1` gets 8 consecutive grants, then `m0` is granted.
- Assert `reset` during `LOCK1` → all outputs 0 immediately; after release, `m0` wins the first contention.
